// File: rtl/fc3_bias_add_pkg.sv
// fc3 bias-add shared constants and lane types.
// Derived values below describe the default fc3 configuration.
package fc3_bias_add_pkg;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int IN_W      = 16;
  localparam int IN_FRAC   = 3;
  localparam int BIAS_W    = 16;
  localparam int BIAS_FRAC = 3;
  localparam int OUT_W     = 16;

  localparam int F         = imax(IN_FRAC, BIAS_FRAC);
  localparam int SUM_WIDTH =
    imax(IN_W - IN_FRAC, BIAS_W - BIAS_FRAC) + F + 1;

  localparam logic signed [OUT_W-1:0] OUT_MAX = 16'sh7fff;
  localparam logic signed [OUT_W-1:0] OUT_MIN = 16'sh8000;

  typedef logic signed [SUM_WIDTH-1:0] sum_t;
  typedef logic signed [OUT_W-1:0]     out_t;

endpackage

// File: rtl/fixed_skid_buffer.sv
// Two-entry skid buffer: registered output plus one overflow slot.
// Upstream ready depends only on the overflow slot being empty.
module fixed_skid_buffer
  import fc3_bias_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic             push, pop;

  assign in_ready  = !skid_v_q;
  assign push      = in_valid && in_ready;
  assign pop       = main_v_q && out_ready;
  assign out_data  = main_q;
  assign out_valid = main_v_q;

  // push implies the skid slot is empty, so pop+push never needs it
  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (push) begin
      if (!main_v_q || pop) begin
        main_d   = in_data;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_data;
        skid_v_d = 1'b1;
      end
    end else if (pop) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

endmodule

// File: rtl/fc3_bias_add.sv
// fc3 bias add: joins matmul and bias streams, aligns, adds,
// rescales and saturates, then emits a row-tagged stream.
module fc3_bias_add
  import fc3_bias_add_pkg::*;
#(
  parameter int DATA_IN_PRECISION_0  = 16,
  parameter int DATA_IN_PRECISION_1  = 3,
  parameter int BIAS_PRECISION_0     = 16,
  parameter int BIAS_PRECISION_1     = 3,
  parameter int DATA_OUT_PRECISION_0 = 16,
  parameter int DATA_OUT_PRECISION_1 = 3,
  parameter int PARALLELISM          = 1,
  parameter int TENSOR_SIZE_DIM_0    = 32,
  parameter int DEPTH = TENSOR_SIZE_DIM_0 / PARALLELISM
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_PRECISION_0-1:0] data_in [PARALLELISM],
  input  logic data_in_valid,
  output logic data_in_ready,
  input  logic [BIAS_PRECISION_0-1:0] bias [PARALLELISM],
  input  logic bias_valid,
  output logic bias_ready,
  output logic [DATA_OUT_PRECISION_0-1:0] data_out [PARALLELISM],
  output logic data_out_valid,
  input  logic data_out_ready,
  output logic data_out_last
);

  localparam int DO_W  = DATA_OUT_PRECISION_0;
  localparam int FB    = imax(DATA_IN_PRECISION_1, BIAS_PRECISION_1);
  localparam int IB    = imax(DATA_IN_PRECISION_0 - DATA_IN_PRECISION_1,
                              BIAS_PRECISION_0 - BIAS_PRECISION_1);
  localparam int SW    = IB + FB + 1;
  localparam int LSH   = imax(DATA_OUT_PRECISION_1 - FB, 0);
  localparam int RSH   = imax(FB - DATA_OUT_PRECISION_1, 0);
  localparam int CW    = imax(SW + LSH, DO_W);
  localparam int PW    = PARALLELISM * DO_W + 1;
  localparam int BW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [BW-1:0] BEAT_MAX = BW'(DEPTH - 1);
  localparam logic signed [CW-1:0] OMAX =
    CW'({1'b0, {(DO_W-1){1'b1}}});
  localparam logic signed [CW-1:0] OMIN = ~OMAX;

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic          can_accept, join_valid, fire;
  logic [BW-1:0] beat_q, beat_d;
  logic          last;
  logic [PW-1:0] buf_in, buf_out;

  logic [PARALLELISM-1:0][DO_W-1:0] res_d, res_out;

  // assert follows rst at once, release is retimed to clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign join_valid    = data_in_valid && bias_valid;
  assign fire          = join_valid && can_accept;
  assign data_in_ready = bias_valid && can_accept;
  assign bias_ready    = data_in_valid && can_accept;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    logic signed [SW-1:0] a_al, b_al, sum;
    logic signed [CW-1:0] conv;
    logic [DO_W-1:0]      lane_res;

    always_comb begin
      a_al = SW'($signed(data_in[i])) <<< (FB - DATA_IN_PRECISION_1);
      b_al = SW'($signed(bias[i])) <<< (FB - BIAS_PRECISION_1);
      sum  = a_al + b_al;
      conv = (CW'(sum) <<< LSH) >>> RSH;
      lane_res = conv[DO_W-1:0];
      if (conv > OMAX)      lane_res = OMAX[DO_W-1:0];
      else if (conv < OMIN) lane_res = OMIN[DO_W-1:0];
    end

    assign res_d[i]    = lane_res;
    assign data_out[i] = res_out[i];
  end

  always_comb begin
    beat_d = beat_q;
    if (fire) beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  assign last   = (beat_q == BEAT_MAX);
  assign buf_in = {res_d, last};

  fixed_skid_buffer #(
    .WIDTH (PW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (buf_in),
    .in_valid  (join_valid),
    .in_ready  (can_accept),
    .out_data  (buf_out),
    .out_valid (data_out_valid),
    .out_ready (data_out_ready)
  );

  assign {res_out, data_out_last} = buf_out;

endmodule

// File: tb/tb_fc3_bias_add.sv
// Directed bench for fc3_bias_add: arithmetic, saturation,
// rescale, row tagging, backpressure ordering and reset.
module tb_fc3_bias_add;

  logic        clk;
  logic        rst;
  logic [15:0] din [1];
  logic        din_v, din_rdy, din_rdy2;
  logic [15:0] bias [1];
  logic [15:0] bias2 [1];
  logic        bias_v, bias_rdy, bias_rdy2;
  logic [15:0] dout [1];
  logic [15:0] dout2 [1];
  logic        dout_v, dout_v2;
  logic        dout_rdy;
  logic        dout_last, dout_last2;

  int checks = 0;
  int failures = 0;

  logic [15:0] qd [$];
  logic        ql [$];
  int          idx;
  int          sb_beat;
  bit          hold;
  logic [15:0] hd;
  logic        hl;
  logic [31:0] exp_d, exp_l;

  fc3_bias_add dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .data_in_valid  (din_v),
    .data_in_ready  (din_rdy),
    .bias           (bias),
    .bias_valid     (bias_v),
    .bias_ready     (bias_rdy),
    .data_out       (dout),
    .data_out_valid (dout_v),
    .data_out_ready (dout_rdy),
    .data_out_last  (dout_last)
  );

  fc3_bias_add #(
    .BIAS_PRECISION_1 (5)
  ) dut2 (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .data_in_valid  (din_v),
    .data_in_ready  (din_rdy2),
    .bias           (bias2),
    .bias_valid     (bias_v),
    .bias_ready     (bias_rdy2),
    .data_out       (dout2),
    .data_out_valid (dout_v2),
    .data_out_ready (dout_rdy),
    .data_out_last  (dout_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic one_beat(input string tag, input logic [15:0] d,
                          input logic [15:0] b, input logic [15:0] b2,
                          input logic [15:0] e1, input logic [15:0] e2,
                          input bit c2);
    din[0] = d; bias[0] = b; bias2[0] = b2;
    din_v = 1'b1; bias_v = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(din_rdy), 32'd1);
    @(posedge clk); #1;
    din_v = 1'b0; bias_v = 1'b0;
    check({tag, "_v"}, 32'(dout_v), 32'd1);
    check(tag, 32'(dout[0]), 32'(e1));
    check({tag, "_last"}, 32'(dout_last), 32'd0);
    if (c2) check({tag, "_q5"}, 32'(dout2[0]), 32'(e2));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; din_v = 1'b0; bias_v = 1'b0; dout_rdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input string tag, input int n);
    @(negedge clk);
    dout_rdy = 1'b1;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        check($sformatf("%s_v%0d", tag, k - 1), 32'(dout_v), 32'd1);
        check($sformatf("%s_d%0d", tag, k - 1), 32'(dout[0]),
              32'((k - 1) * 9));
        check($sformatf("%s_l%0d", tag, k - 1), 32'(dout_last),
              32'(((k - 1) % 32) == 31));
      end
      if (k < n) begin
        din[0] = 16'(k * 8); bias[0] = 16'(k);
        din_v = 1'b1; bias_v = 1'b1;
      end else begin
        din_v = 1'b0; bias_v = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    din[0] = '0; bias[0] = '0; bias2[0] = '0;
    din_v = 1'b0; bias_v = 1'b0; dout_rdy = 1'b1;
    #2;
    check("rst_valid", 32'(dout_v), 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    check("rst_data", 32'(dout[0]), 32'd0);

    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_fire_valid", 32'(dout_v), 32'd0);

    one_beat("add_2p0_1p0", 16'd16, 16'd8, 16'd0, 16'd24, 16'd0, 1'b0);
    one_beat("sat_pos", 16'h7ff0, 16'h0100, 16'd0, 16'h7fff, 16'd0, 1'b0);
    one_beat("sat_neg", 16'h8000, 16'hff00, 16'd0, 16'h8000, 16'd0, 1'b0);
    one_beat("neg_add", 16'hfff0, 16'h0004, 16'd0, 16'hfff4, 16'd0, 1'b0);
    one_beat("frac5", 16'd8, 16'd0, 16'd32, 16'd8, 16'd16, 1'b1);
    one_beat("trunc_pos", 16'd1, 16'd0, 16'd1, 16'd1, 16'd1, 1'b1);
    one_beat("trunc_neg", 16'hffff, 16'd0, 16'hffff, 16'hffff,
             16'hfffe, 1'b1);

    // join: neither side consumed alone
    din_v = 1'b1; bias_v = 1'b0;
    #1;
    check("join_din_rdy", 32'(din_rdy), 32'd0);
    check("join_bias_rdy", 32'(bias_rdy), 32'd1);
    @(posedge clk); #1;
    check("join_nofire_a", 32'(dout_v), 32'd0);
    din_v = 1'b0; bias_v = 1'b1;
    #1;
    check("join_din_rdy_b", 32'(din_rdy), 32'd1);
    check("join_bias_rdy_b", 32'(bias_rdy), 32'd0);
    @(posedge clk); #1;
    check("join_nofire_b", 32'(dout_v), 32'd0);
    bias_v = 1'b0;

    // skid fill under backpressure
    @(negedge clk);
    dout_rdy = 1'b0;
    din[0] = 16'd100; bias[0] = 16'd1; din_v = 1'b1; bias_v = 1'b1;
    @(posedge clk); #1;
    check("skid_a_data", 32'(dout[0]), 32'd101);
    check("skid_a_rdy", 32'(din_rdy), 32'd1);
    din[0] = 16'd200; bias[0] = 16'd2;
    @(posedge clk); #1;
    din_v = 1'b0; bias_v = 1'b0;
    check("skid_full_rdy", 32'(din_rdy), 32'd0);
    check("skid_hold_a", 32'(dout[0]), 32'd101);
    @(posedge clk); #1;
    check("skid_hold_a2", 32'(dout[0]), 32'd101);
    check("skid_hold_v", 32'(dout_v), 32'd1);
    dout_rdy = 1'b1;
    @(posedge clk); #1;
    check("skid_b_data", 32'(dout[0]), 32'd202);
    check("skid_b_v", 32'(dout_v), 32'd1);
    din_v = 1'b1;
    #1;
    check("skid_drain_rdy", 32'(bias_rdy), 32'd1);
    din_v = 1'b0;
    @(posedge clk); #1;
    check("skid_empty_v", 32'(dout_v), 32'd0);

    do_reset();
    run_burst("burst", 64);

    // ready toggling with random bias gaps against a scoreboard
    @(posedge clk); #1;
    idx = 0; sb_beat = 0; hold = 1'b0; hd = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 400 && !(idx == 40 && qd.size() == 0);
         cyc++) begin
      dout_rdy = (cyc % 2) == 0;
      bias_v = ($urandom_range(0, 3) != 0);
      din_v = (idx < 40);
      din[0] = 16'(idx * 24); bias[0] = 16'(idx);
      @(negedge clk);
      if (hold) begin
        check("stall_v", 32'(dout_v), 32'd1);
        check("stall_data", 32'(dout[0]), 32'(hd));
        check("stall_last", 32'(dout_last), 32'(hl));
      end
      if (dout_v && dout_rdy) begin
        exp_d = 'x; exp_l = 'x;
        if (qd.size() != 0) begin
          exp_d = 32'(qd.pop_front());
          exp_l = 32'(ql.pop_front());
        end
        check("sb_data", 32'(dout[0]), exp_d);
        check("sb_last", 32'(dout_last), exp_l);
      end
      hold = dout_v && !dout_rdy;
      hd = dout[0]; hl = dout_last;
      if (din_v && bias_v && din_rdy) begin
        qd.push_back(16'(idx * 25));
        ql.push_back(sb_beat == 31);
        sb_beat = (sb_beat + 1) % 32;
        idx++;
      end
      @(posedge clk); #1;
    end
    din_v = 1'b0; bias_v = 1'b0; dout_rdy = 1'b1;
    check("sb_sent", 32'(idx), 32'd40);
    check("sb_drained", 32'(qd.size()), 32'd0);

    // reset in the middle of a row (beats 8, 9, 10)
    din[0] = 16'd300; bias[0] = 16'd1;
    din_v = 1'b1; bias_v = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_v", 32'(dout_v), 32'd1);
    check("mid_data", 32'(dout[0]), 32'd301);
    check("mid_last", 32'(dout_last), 32'd0);
    rst = 1'b0;
    #1;
    check("async_rst_v", 32'(dout_v), 32'd0);
    check("async_rst_data", 32'(dout[0]), 32'd0);
    check("async_rst_last", 32'(dout_last), 32'd0);
    din_v = 1'b0; bias_v = 1'b0;
    @(posedge clk); #1;
    check("in_rst_v", 32'(dout_v), 32'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_burst("post_rst", 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc3_bias_add.md
Name: fc3_bias_add

Overview:
- Streaming bias-add stage for fc3, directly downstream of fc3_bias_source.
- Joins the matmul result stream (data_in) with the bias stream, per lane.
- Aligns fixed-point formats, adds, then rescales and saturates to the output format.
- Emits a handshaked stream with an end-of-row flag; registered output, full throughput.

Parameters:
- DATA_IN_PRECISION_0, 16, data_in lane width (signed).
- DATA_IN_PRECISION_1, 3, data_in fractional bits.
- BIAS_PRECISION_0, 16, bias lane width (signed).
- BIAS_PRECISION_1, 3, bias fractional bits.
- DATA_OUT_PRECISION_0, 16, data_out lane width (signed).
- DATA_OUT_PRECISION_1, 3, data_out fractional bits.
- PARALLELISM, 1, lanes per beat; must equal the bias source parallelism.
- TENSOR_SIZE_DIM_0, 32, bias elements per row.
- DEPTH, TENSOR_SIZE_DIM_0/PARALLELISM, beats per row.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_IN_PRECISION_0 x PARALLELISM  matmul lanes (unpacked array).
- data_in_valid  in  1  data_in valid.
- data_in_ready  out  1  data_in ready.
- bias  in  BIAS_PRECISION_0 x PARALLELISM  bias lanes from fc3_bias_source.
- bias_valid  in  1  bias valid.
- bias_ready  out  1  bias ready; drives fc3_bias_source data_out_ready.
- data_out  out  DATA_OUT_PRECISION_0 x PARALLELISM  result lanes.
- data_out_valid  out  1  result valid.
- data_out_ready  in  1  downstream ready.
- data_out_last  out  1  high on the last beat of a row (beat index DEPTH-1).

Behaviour:
- Reset (rst low, asynchronous assert):
  - data_out_valid=0, data_out_last=0, data_out=0.
  - Skid buffer empty; beat counter=0.
  - Release is synchronised to clk internally (2-flop).
- Join:
  - fire = data_in_valid && bias_valid && can_accept.
  - data_in_ready = bias_valid && can_accept.
  - bias_ready = data_in_valid && can_accept.
  - Neither stream is consumed without the other.
  - Ready must not depend on data_out_ready combinationally; it depends only on registered buffer state.
- Arithmetic, per lane:
  - F = max(DATA_IN_PRECISION_1, BIAS_PRECISION_1).
  - Left-shift each operand by F minus its own fractional bits, sign-extended.
  - Sum width = max(integer bits) + F + 1; no overflow is possible.
  - Output conversion: if DATA_OUT_PRECISION_1 < F, arithmetic right shift (truncate toward -inf); otherwise left shift.
  - Saturate to the signed DATA_OUT_PRECISION_0 range.
- Buffering: 2-entry skid buffer (main + skid register).
  - can_accept = skid entry empty.
  - Latency: fire at cycle N -> data_out_valid at N+1.
  - Sustains 1 beat/cycle when data_out_ready stays high.
  - When data_out_ready drops, one extra in-flight beat lands in skid; can_accept falls the next cycle.
  - data_out/data_out_last are stable while valid && !ready (AXI-stream rule).
- Beat counter:
  - Increments on fire; wraps from DEPTH-1 to 0.
  - data_out_last travels with its beat through the buffer.
  - Must track the bias source address exactly; both are reset by the same rst.
- Simultaneous pop and push in the same cycle:
  - Buffer occupancy stays unchanged.
  - Order is preserved, no bubble.
- Reset mid-row: in-flight beats are discarded; counter returns to 0.

Decomposition:
- Package fc3_bias_add_pkg:
  - Derived constants: F, SUM_WIDTH, OUT_MAX, OUT_MIN.
  - Lane typedefs for the sum and output words.
- One sub-module, fixed_skid_buffer:
  - 2-entry, parameterised payload width.
  - Payload = flattened lanes + last bit.
- The align/add/saturate logic stays inline as a generate loop over lanes.

Test Plan:
- Defaults, data_in=16 (2.0), bias=8 (1.0), ready high -> data_out=24 one cycle after fire.
- data_in=0x7FF0, bias=0x0100 -> data_out saturates to 0x7FFF; data_in=0x8000, bias=0xFF00 -> data_out=0x8000.
- BIAS_PRECISION_1=5, bias=32 (1.0), data_in=8 (1.0) -> data_out=16 (2.0).
- 64 back-to-back beats, ready high:
  - 64 outputs, no bubbles.
  - data_out_last high on beats 31 and 63 only.
- data_out_ready toggled 1-0-1 every cycle, plus random bias_valid gaps:
  - No beat lost or duplicated; order matches the scoreboard.
  - data_out is stable while stalled.
- Reset asserted at beat 10 of a row:
  - data_out_valid drops immediately (asynchronous).
  - After release, the first output has counter 0; last appears at beat 31.
